// File: rtl/lsu_align_sequencer.sv
// Load/store sequencer in front of data memory.
// Aligned accesses go straight through; misaligned ones become byte sequences.
module lsu_align_sequencer #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  busy,
   output logic                  dm_MemRead,
   output logic                  dm_MemWrite,
   output logic [DM_ADDRESS-1:0] dm_a,
   output logic [DATA_W-1:0]     dm_wd,
   output logic [2:0]            dm_Funct3,
   input  logic [DATA_W-1:0]     dm_rd
);

   typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, RESP} state_t;

   state_t                state;
   logic                  we_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [2:0]            f3_q;
   logic [1:0]            idx;
   logic [23:0]           byte_buf;

   logic                  illegal;
   logic                  mis;
   logic [1:0]            last_idx;
   logic [1:0]            idx_n;
   logic [DATA_W-1:0]     asm_w;

   assign illegal = (req_funct3[1:0] == 2'b11)
                  | (req_funct3[2] & req_funct3[1])
                  | (req_we & req_funct3[2]);

   assign mis = ((req_funct3[1:0] == 2'b01) & req_addr[0])
              | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

   assign last_idx = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
   assign idx_n    = idx + 2'd1;

   // buffered bytes plus the byte arriving this cycle
   always_comb begin
      asm_w = DATA_W'(byte_buf);
      asm_w[{idx, 3'b000} +: 8] = dm_rd[7:0];
   end

   function automatic logic [DATA_W-1:0] ext(
      input logic [2:0]        f,
      input logic [DATA_W-1:0] w
   );
      logic [DATA_W-1:0] r;
      case (f)
         3'b000:  r = {{(DATA_W-8){w[7]}}, w[7:0]};
         3'b001:  r = {{(DATA_W-16){w[15]}}, w[15:0]};
         3'b100:  r = {{(DATA_W-8){1'b0}}, w[7:0]};
         3'b101:  r = {{(DATA_W-16){1'b0}}, w[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         f3_q        <= '0;
         idx         <= '0;
         byte_buf    <= '0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         dm_MemRead  <= 1'b0;
         dm_MemWrite <= 1'b0;
         dm_a        <= '0;
         dm_wd       <= '0;
         dm_Funct3   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  f3_q      <= req_funct3;
                  idx       <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (illegal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (!mis) begin
                     state       <= SINGLE;
                     dm_a        <= req_addr;
                     dm_Funct3   <= (req_funct3 == 3'b101) ? 3'b001
                                                           : req_funct3;
                     dm_MemWrite <= req_we;
                     dm_MemRead  <= !req_we;
                     if (req_we)
                        dm_wd <= req_wdata;
                  end else begin
                     state       <= SPLIT;
                     dm_a        <= req_addr;
                     dm_Funct3   <= req_we ? 3'b000 : 3'b100;
                     dm_MemWrite <= req_we;
                     dm_MemRead  <= !req_we;
                     if (req_we)
                        dm_wd <= DATA_W'(req_wdata[7:0]);
                  end
               end
            end
            SINGLE: begin
               state       <= RESP;
               dm_MemRead  <= 1'b0;
               dm_MemWrite <= 1'b0;
               resp_valid  <= 1'b1;
               resp_err    <= 1'b0;
               resp_rdata  <= we_q ? '0 : ext(f3_q, dm_rd);
            end
            SPLIT: begin
               if (!we_q)
                  byte_buf <= asm_w[23:0];
               if (idx == last_idx) begin
                  state       <= RESP;
                  dm_MemRead  <= 1'b0;
                  dm_MemWrite <= 1'b0;
                  resp_valid  <= 1'b1;
                  resp_err    <= 1'b0;
                  resp_rdata  <= we_q ? '0 : ext(f3_q, asm_w);
               end else begin
                  idx  <= idx_n;
                  dm_a <= addr_q + DM_ADDRESS'(idx_n);
                  if (we_q)
                     dm_wd <= DATA_W'(wdata_q[{idx_n, 3'b000} +: 8]);
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align_sequencer.sv
// Directed bench for lsu_align_sequencer with a byte-array data memory model.
// Memory returns loads extended per Funct3, valid in the same cycle.
module tb_lsu_align_sequencer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        dm_MemRead;
   logic        dm_MemWrite;
   logic [8:0]  dm_a;
   logic [31:0] dm_wd;
   logic [2:0]  dm_Funct3;
   logic [31:0] dm_rd;

   int nchk;
   int nerr;

   logic [7:0]  mem [512];
   logic [8:0]  a1, a2, a3;

   logic [8:0]  la  [8];
   logic [2:0]  lf  [8];
   logic [31:0] lw  [8];
   logic        lwe [8];
   int          nacc;

   lsu_align_sequencer #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_funct3(req_funct3),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .busy(busy),
      .dm_MemRead(dm_MemRead),
      .dm_MemWrite(dm_MemWrite),
      .dm_a(dm_a),
      .dm_wd(dm_wd),
      .dm_Funct3(dm_Funct3),
      .dm_rd(dm_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign a1 = dm_a + 9'd1;
   assign a2 = dm_a + 9'd2;
   assign a3 = dm_a + 9'd3;

   always_comb begin
      dm_rd = 32'h0;
      case (dm_Funct3)
         3'b000: dm_rd = {{24{mem[dm_a][7]}}, mem[dm_a]};
         3'b100: dm_rd = {24'h0, mem[dm_a]};
         3'b001: dm_rd = {{16{mem[a1][7]}}, mem[a1], mem[dm_a]};
         3'b101: dm_rd = {16'h0, mem[a1], mem[dm_a]};
         3'b010: dm_rd = {mem[a3], mem[a2], mem[a1], mem[dm_a]};
         default: dm_rd = 32'h0;
      endcase
   end

   // preload while in reset, otherwise commit stores
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 512; i++) mem[i] = 8'h00;
         mem[9'h002] = 8'h5A; mem[9'h003] = 8'hC3;
         mem[9'h004] = 8'h55; mem[9'h005] = 8'h66;
         mem[9'h006] = 8'h77; mem[9'h007] = 8'h88;
         mem[9'h008] = 8'hAA; mem[9'h009] = 8'hBB;
         mem[9'h00A] = 8'hCC; mem[9'h00B] = 8'hDD;
      end else if (dm_MemWrite) begin
         mem[dm_a] = dm_wd[7:0];
         if (dm_Funct3[1:0] != 2'b00) mem[a1] = dm_wd[15:8];
         if (dm_Funct3[1:0] == 2'b10) begin
            mem[a2] = dm_wd[23:16];
            mem[a3] = dm_wd[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run(input logic we, input logic [8:0] a,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input int exp_lat, input int exp_n,
                      input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      @(negedge clk);
      check("ready_idle", req_ready, 1);
      req_we     = we;
      req_addr   = a;
      req_wdata  = wd;
      req_funct3 = f3;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      nacc = 0;
      lat  = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         check("excl", dm_MemRead & dm_MemWrite, 0);
         if (dm_MemRead || dm_MemWrite) begin
            if (nacc < 8) begin
               la[nacc]  = dm_a;
               lf[nacc]  = dm_Funct3;
               lw[nacc]  = dm_wd;
               lwe[nacc] = dm_MemWrite;
            end
            nacc++;
         end
         if (resp_valid) begin
            lat = k;
            check("rdata", resp_rdata, exp_rd);
            check("err", resp_err, exp_err);
            check("ready_resp", req_ready, 0);
         end
      end
      check("latency", lat, exp_lat);
      check("n_access", nacc, exp_n);
      if (lat != 0) begin
         @(negedge clk);
         check("pulse", resp_valid, 0);
         check("ready_after", req_ready, 1);
         check("busy_after", busy, 0);
         check("hold", resp_rdata, exp_rd);
      end
   endtask

   initial begin
      nchk       = 0;
      nerr       = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_strobe", {dm_MemRead, dm_MemWrite}, 0);
      check("rst_a", dm_a, 0);
      check("rst_f3", dm_Funct3, 0);
      check("rst_wd", dm_wd, 0);
      rst_n = 1'b1;

      run(1'b0, 9'h004, 0, 3'b010, 2, 1, 32'h88776655, 1'b0);
      check("lw_a", la[0], 9'h004);
      check("lw_f3", lf[0], 3'b010);
      check("lw_rd", lwe[0], 0);

      run(1'b0, 9'h006, 0, 3'b010, 5, 4, 32'hBBAA8877, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("mlw_a", la[i], 9'h006 + 9'(i));
         check("mlw_f3", lf[i], 3'b100);
         check("mlw_rd", lwe[i], 0);
      end

      run(1'b0, 9'h007, 0, 3'b001, 3, 2, 32'hFFFFAA88, 1'b0);
      check("lh_a1", la[1], 9'h008);
      run(1'b0, 9'h007, 0, 3'b101, 3, 2, 32'h0000AA88, 1'b0);
      check("lhu_f3", lf[0], 3'b100);

      run(1'b0, 9'h007, 0, 3'b000, 2, 1, 32'hFFFFFF88, 1'b0);
      run(1'b0, 9'h008, 0, 3'b101, 2, 1, 32'h0000BBAA, 1'b0);
      check("lhu_al_f3", lf[0], 3'b001);

      run(1'b1, 9'h1FE, 32'h11223344, 3'b010, 5, 4, 32'h0, 1'b0);
      check("sw_a0", la[0], 9'h1FE);
      check("sw_a1", la[1], 9'h1FF);
      check("sw_a2", la[2], 9'h000);
      check("sw_a3", la[3], 9'h001);
      check("sw_wd0", lw[0], 32'h44);
      check("sw_wd1", lw[1], 32'h33);
      check("sw_wd2", lw[2], 32'h22);
      check("sw_wd3", lw[3], 32'h11);
      check("sw_f3", lf[3], 3'b000);
      check("sw_we", lwe[2], 1);
      check("mem_1fe", mem[9'h1FE], 8'h44);
      check("mem_1ff", mem[9'h1FF], 8'h33);
      run(1'b0, 9'h000, 0, 3'b010, 2, 1, 32'hC35A1122, 1'b0);

      run(1'b0, 9'h004, 0, 3'b011, 1, 0, 32'h0, 1'b1);
      run(1'b1, 9'h004, 32'hFFFFFFFF, 3'b100, 1, 0, 32'h0, 1'b1);

      // abort a misaligned store in its third byte
      @(negedge clk);
      req_we     = 1'b1;
      req_addr   = 9'h005;
      req_wdata  = 32'hA1B2C3D4;
      req_funct3 = 3'b010;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("ab_wr", dm_MemWrite, 1);
      check("ab_a", dm_a, 9'h007);
      check("ab_wd", dm_wd, 32'hB2);
      #1 rst_n = 1'b0;
      #1;
      check("ab_wr_drop", dm_MemWrite, 0);
      check("ab_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            seen = seen | resp_valid;
         end
         check("ab_no_resp", seen, 0);
      end
      check("ab_ready", req_ready, 1);
      check("ab_busy2", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/lsu_align_sequencer.md
Name: lsu_align_sequencer

Overview:
Load/store sequencer that sits directly upstream of the data memory. It accepts one load/store request at a time from the core's MEM stage and drives the memory port signals: MemRead, MemWrite, byte address, write data and Funct3. Naturally aligned accesses pass through as a single memory access. Misaligned halfword and word accesses are split into sequential byte accesses; load bytes are reassembled and sign- or zero-extended locally. The core stalls on busy.

Parameters:
DM_ADDRESS, 9, width of the byte address into data memory
DATA_W, 32, data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_addr  input  DM_ADDRESS  byte address
req_wdata  input  DATA_W  store data
req_funct3  input  3  instruction bits 14:12
resp_valid  output  1  one-cycle completion pulse for loads and stores
resp_rdata  output  DATA_W  extended load result; 0 for stores and errors
resp_err  output  1  qualifies resp_valid; illegal funct3
busy  output  1  high in any state other than IDLE
dm_MemRead  output  1  to data memory MemRead
dm_MemWrite  output  1  to data memory MemWrite
dm_a  output  DM_ADDRESS  to data memory address
dm_wd  output  DATA_W  to data memory write data
dm_Funct3  output  3  to data memory Funct3
dm_rd  input  DATA_W  from data memory read data; valid in the same cycle as the address

Behaviour:
- Reset: state=IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0, busy=0. dm_MemRead=0, dm_MemWrite=0, dm_a=0, dm_wd=0, dm_Funct3=0. Internal byte buffer and index are cleared.
- Reset is asynchronous. If asserted mid-operation, dm strobes drop immediately and the pending response is discarded.
- All outputs are derived from registered state. No combinational path exists from req_* to dm_*.
- Size decode from funct3:
  - 000 LB/SB and 100 LBU: size 1.
  - 001 LH/SH and 101 LHU: size 2.
  - 010 LW/SW: size 4.
- Illegal funct3: 011, 110 and 111 for any access, and 100 or 101 when req_we=1.
- Misalignment:
  - Size 2 is misaligned when addr[0]=1.
  - Size 4 is misaligned when addr[1:0]!=0.
- IDLE: on req_valid, latch we, addr, wdata and funct3. Next state:
  - Illegal funct3: RESP with err=1.
  - Aligned access: SINGLE.
  - Misaligned access: SPLIT with idx=0.
- SINGLE (1 cycle):
  - dm_a=addr.
  - dm_Funct3=funct3, except LHU, which issues 001.
  - Strobe: store sets dm_MemWrite=1 and dm_wd=wdata; load sets dm_MemRead=1.
  - Loads capture dm_rd; LHU result is zero-extended from bits 15:0.
  - Next state: RESP.
- SPLIT (size cycles, idx=0..size-1):
  - dm_a = addr+idx, modulo 2^DM_ADDRESS (wraps 0x1FF to 0x000).
  - Load: dm_Funct3=100 and dm_MemRead=1; capture dm_rd[7:0] into buffer byte idx.
  - Store: dm_Funct3=000, dm_MemWrite=1, dm_wd = {24'b0, wdata byte idx}.
  - When idx=size-1, next state is RESP.
- RESP (1 cycle):
  - resp_valid=1, resp_err=err.
  - Load result is assembled little-endian and extended per the original funct3: LB and LH sign-extend, LBU and LHU zero-extend, LW unextended.
  - Next state: IDLE. A new request is not accepted in this cycle.
- Latency, with acceptance at cycle T:
  - Aligned: SINGLE at T+1, resp_valid at T+2.
  - Misaligned: resp_valid at T+1+size.
  - Error: resp_valid at T+1, with no dm strobe at any time.
- Back-to-back requests: the next acceptance is no earlier than the cycle after RESP.
- In IDLE and RESP: dm_MemRead=dm_MemWrite=0.
- dm_MemRead and dm_MemWrite are never both 1.
- resp_rdata holds its value until the next RESP.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.

Test Plan:
1. Memory preload: 0x004=0x88776655, 0x008=0xDDCCBBAA. Aligned LW at 0x004 -> one dm read with funct3 010; resp_valid at T+2; rdata=0x88776655.
2. Misaligned LW at 0x006 -> dm byte reads at 0x006, 0x007, 0x008, 0x009 with funct3 100; resp_valid at T+5; rdata=0xBBAA8877.
3. LH at 0x007 -> rdata=0xFFFFAA88. LHU at 0x007 -> rdata=0x0000AA88. Each takes 2 byte reads and completes at T+3.
4. SW at 0x1FE with wdata 0x11223344 -> SB 0x44@0x1FE, 0x33@0x1FF, 0x22@0x000, 0x11@0x001. Then LW at 0x000 reads 0x????1122 (upper bytes unchanged).
5. Load with funct3 011, then store with funct3 100 -> each gives resp_valid with resp_err=1 at T+1 and rdata=0; dm_MemRead and dm_MemWrite stay 0.
6. Reset asserted during SPLIT idx=2 of a misaligned SW -> dm_MemWrite falls in the same cycle; no resp_valid; after release req_ready=1 and busy=0.
